// File: rtl/gemm_pkg.sv
// Shared GEMM datapath definitions: default widths, write-back FSM encoding
// and the default output saturation bounds.
package gemm_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int PSUM_WIDTH      = 32;
    localparam int PE_SIZE         = 14;
    localparam int TILE_NUM        = 5;
    localparam int MEM2_ADDR_WIDTH = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        READ  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } wb_state_t;

    localparam int SAT_MAX = (2 ** (DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DATA_WIDTH - 1));

endpackage

// File: rtl/acc_writeback_if.sv
// ACC-FIFO pop side and output-GLB write port of the write-back engine.
interface acc_writeback_if
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH      = gemm_pkg::DATA_WIDTH,
    parameter int PSUM_WIDTH      = gemm_pkg::PSUM_WIDTH,
    parameter int PE_SIZE         = gemm_pkg::PE_SIZE,
    parameter int MEM2_ADDR_WIDTH = gemm_pkg::MEM2_ADDR_WIDTH
);
    logic                            acc_rdy_i;
    logic                            acc_rden_o;
    logic [PE_SIZE*PSUM_WIDTH-1:0]   acc_row_i;
    logic [MEM2_ADDR_WIDTH-1:0]      mem2_addr0;
    logic                            mem2_ce0;
    logic                            mem2_we0;
    logic [PE_SIZE*DATA_WIDTH-1:0]   mem2_d0;

    modport master (
        input  acc_rdy_i, acc_row_i,
        output acc_rden_o, mem2_addr0, mem2_ce0, mem2_we0, mem2_d0
    );

    modport slave (
        output acc_rdy_i, acc_row_i,
        input  acc_rden_o, mem2_addr0, mem2_ce0, mem2_we0, mem2_d0
    );
endinterface

// File: rtl/psum_requant.sv
// Single-lane requantizer: arithmetic right shift, optional ReLU, signed
// saturation of a partial sum down to the output element width.
module psum_requant
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH = gemm_pkg::DATA_WIDTH,
    parameter int PSUM_WIDTH = gemm_pkg::PSUM_WIDTH,
    parameter int SAT_HI     = SAT_MAX,
    parameter int SAT_LO     = SAT_MIN
) (
    input  logic signed [PSUM_WIDTH-1:0] psum,
    input  logic        [4:0]            shift,
    input  logic                         relu_en,
    output logic        [DATA_WIDTH-1:0] q
);
    localparam logic signed [PSUM_WIDTH-1:0] HI = PSUM_WIDTH'(SAT_HI);
    localparam logic signed [PSUM_WIDTH-1:0] LO = PSUM_WIDTH'(SAT_LO);

    logic signed [PSUM_WIDTH-1:0] shifted_s;
    logic signed [PSUM_WIDTH-1:0] relu_s;

    // Shift, rectify and clamp one lane
    always_comb begin
        shifted_s = psum >>> shift;
        if (relu_en && shifted_s[PSUM_WIDTH-1]) begin
            relu_s = {PSUM_WIDTH{1'b0}};
        end else begin
            relu_s = shifted_s;
        end
        if (relu_s > HI) begin
            q = HI[DATA_WIDTH-1:0];
        end else if (relu_s < LO) begin
            q = LO[DATA_WIDTH-1:0];
        end else begin
            q = relu_s[DATA_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/acc_writeback.sv
// Drains completed PSUM rows from the ACC FIFOs, requantizes every lane and
// writes packed rows to the output GLB; two-cycle pop-to-write pipeline.
module acc_writeback
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH      = gemm_pkg::DATA_WIDTH,
    parameter int PSUM_WIDTH      = gemm_pkg::PSUM_WIDTH,
    parameter int PE_SIZE         = gemm_pkg::PE_SIZE,
    parameter int TILE_NUM        = gemm_pkg::TILE_NUM,
    parameter int MEM2_ADDR_WIDTH = gemm_pkg::MEM2_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [MEM2_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [4:0]                 shift_i,
    input  logic                       relu_en_i,
    acc_writeback_if.master            bus,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int ROW_W  = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
    localparam int TILE_W = $clog2(TILE_NUM + 1);

    wb_state_t                      state_r;
    logic [ROW_W-1:0]               row_cnt_r;
    logic [TILE_W-1:0]              tile_cnt_r;
    logic                           flush_cnt_r;
    logic [4:0]                     shift_r;
    logic                           relu_r;
    logic                           acc_rden_r;
    logic                           busy_r;
    logic                           done_r;
    logic                           rd_vld_r;
    logic [MEM2_ADDR_WIDTH-1:0]     wr_addr_r;
    logic [MEM2_ADDR_WIDTH-1:0]     mem2_addr_r;
    logic                           mem2_ce_r;
    logic                           mem2_we_r;
    logic [PE_SIZE*DATA_WIDTH-1:0]  mem2_d_r;
    logic [PE_SIZE*DATA_WIDTH-1:0]  row_q_s;
    logic                           start_acc_s;

    assign start_acc_s = (state_r == IDLE) && start_i;

    // Run sequencing: tile handshakes, row pops, pipeline flush, done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            row_cnt_r   <= {ROW_W{1'b0}};
            tile_cnt_r  <= {TILE_W{1'b0}};
            flush_cnt_r <= 1'b0;
            shift_r     <= 5'd0;
            relu_r      <= 1'b0;
            acc_rden_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        shift_r    <= shift_i;
                        relu_r     <= relu_en_i;
                        tile_cnt_r <= {TILE_W{1'b0}};
                        row_cnt_r  <= {ROW_W{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus.acc_rdy_i) begin
                        acc_rden_r <= 1'b1;
                        row_cnt_r  <= {ROW_W{1'b0}};
                        state_r    <= READ;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                READ: begin
                    if (row_cnt_r == ROW_W'(PE_SIZE - 1)) begin
                        acc_rden_r <= 1'b0;
                        row_cnt_r  <= {ROW_W{1'b0}};
                        tile_cnt_r <= tile_cnt_r + TILE_W'(1);
                        if (tile_cnt_r == TILE_W'(TILE_NUM - 1)) begin
                            flush_cnt_r <= 1'b0;
                            state_r     <= FLUSH;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        row_cnt_r <= row_cnt_r + ROW_W'(1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt_r) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        flush_cnt_r <= 1'b1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    acc_rden_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        psum_requant #(
            .DATA_WIDTH (DATA_WIDTH),
            .PSUM_WIDTH (PSUM_WIDTH),
            .SAT_HI     ((2 ** (DATA_WIDTH - 1)) - 1),
            .SAT_LO     (-(2 ** (DATA_WIDTH - 1)))
        ) u_requant (
            .psum    (bus.acc_row_i[k*PSUM_WIDTH +: PSUM_WIDTH]),
            .shift   (shift_r),
            .relu_en (relu_r),
            .q       (row_q_s[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Capture the returned row one cycle after the pop and present the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_r    <= 1'b0;
            wr_addr_r   <= {MEM2_ADDR_WIDTH{1'b0}};
            mem2_addr_r <= {MEM2_ADDR_WIDTH{1'b0}};
            mem2_ce_r   <= 1'b0;
            mem2_we_r   <= 1'b0;
            mem2_d_r    <= {(PE_SIZE*DATA_WIDTH){1'b0}};
        end else begin
            rd_vld_r <= acc_rden_r;
            if (start_acc_s) begin
                wr_addr_r <= base_addr_i;
            end else if (rd_vld_r) begin
                wr_addr_r <= wr_addr_r + MEM2_ADDR_WIDTH'(1);
            end else begin
                wr_addr_r <= wr_addr_r;
            end
            if (rd_vld_r) begin
                mem2_ce_r   <= 1'b1;
                mem2_we_r   <= 1'b1;
                mem2_addr_r <= wr_addr_r;
                mem2_d_r    <= row_q_s;
            end else begin
                mem2_ce_r <= 1'b0;
                mem2_we_r <= 1'b0;
            end
        end
    end

    assign bus.acc_rden_o = acc_rden_r;
    assign bus.mem2_addr0 = mem2_addr_r;
    assign bus.mem2_ce0   = mem2_ce_r;
    assign bus.mem2_we0   = mem2_we_r;
    assign bus.mem2_d0    = mem2_d_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
endmodule

// File: tb/tb_acc_writeback.sv
// Self-checking bench for acc_writeback: ACC responder model, write-port
// scoreboard, requantization vector table and multi-cycle corner sequences.
module tb_acc_writeback;
    localparam int PE   = 4;
    localparam int TN   = 2;
    localparam int DW   = 8;
    localparam int PW   = 32;
    localparam int AW   = 11;
    localparam int ROWS = PE * TN;

    typedef struct packed {
        logic [AW-1:0]    base;
        logic [4:0]       shift;
        logic             relu;
        logic [PE*PW-1:0] row;
        logic [PE*DW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [4:0]    shift_i;
    logic          relu_en_i;
    logic          busy_o;
    logic          done_o;

    acc_writeback_if #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .PE_SIZE(PE), .MEM2_ADDR_WIDTH(AW)) bus ();

    acc_writeback #(
        .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .PE_SIZE(PE), .TILE_NUM(TN), .MEM2_ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .shift_i     (shift_i),
        .relu_en_i   (relu_en_i),
        .bus         (bus.master),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [PE*PW-1:0]    rows_q[$];
    logic [PE*DW-1:0]    exp_dq[$];
    logic [AW+PE*DW-1:0] sb_q[$];
    logic [AW+PE*DW-1:0] sb_exp;
    logic [AW-1:0]       exp_addr = '0;
    logic                resp_pop;
    int cyc = 0, pop_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int first_pop_cyc = -1, last_pop_cyc = -1, first_wr_cyc = -1, done_cyc = -1;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [PE*PW-1:0] row, input logic [PE*DW-1:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            rows_q.push_back(row);
            exp_dq.push_back(exp);
        end
    endtask

    task automatic load_basic();
        for (int r = 0; r < ROWS; r++) begin
            load({4{PW'(r % PE + 1)}}, {4{DW'(r % PE + 1)}}, 1);
        end
    endtask

    // ACC model: a pop in cycle t returns the next row during t+1
    always @(posedge clk) begin
        resp_pop = bus.acc_rden_o;
        #1;
        if (resp_pop === 1'b1) begin
            if (rows_q.size() > 0 && exp_dq.size() > 0) begin
                bus.acc_row_i = rows_q.pop_front();
                sb_q.push_back({exp_addr, exp_dq.pop_front()});
                exp_addr = exp_addr + 1'b1;
            end else begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_underflow: pop issued with %0d rows available", rows_q.size());
            end
        end
    end

    // Output monitor and write scoreboard
    always @(negedge clk) begin
        cyc++;
        if (bus.acc_rden_o === 1'b1) begin
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (bus.mem2_ce0 === 1'b1) begin
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL write_unexpected: addr 0x%0h data 0x%0h, none pending", bus.mem2_addr0, bus.mem2_d0);
            end else begin
                sb_exp = sb_q.pop_front();
                check("write", {bus.mem2_we0, bus.mem2_addr0, bus.mem2_d0}, {1'b1, sb_exp});
            end
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic do_run(input logic [AW-1:0] base, input logic [4:0] sh, input logic rl,
                          input bit gap, input bit restart, input string tag);
        int p0, w0, d0, t, pg, wg;
        p0 = pop_cnt; w0 = wr_cnt; d0 = done_cnt;
        first_pop_cyc = -1; first_wr_cyc = -1;
        exp_addr = base;
        start_i = 1'b1; base_addr_i = base; shift_i = sh; relu_en_i = rl;
        tick();
        start_i = 1'b0; base_addr_i = 11'h155; shift_i = 5'd7; relu_en_i = ~rl;
        tick();
        check($sformatf("%s_busy", tag), 64'(busy_o), 64'd1);
        if (restart) begin
            start_i = 1'b1; base_addr_i = 11'h100;
            tick();
            start_i = 1'b0;
        end
        if (gap) begin
            t = 0;
            while (pop_cnt - p0 < PE && t < 100) begin tick(); t++; end
            bus.acc_rdy_i = 1'b0;
            tick(); tick();
            check($sformatf("%s_tile0_writes", tag), 64'(wr_cnt - w0), 64'(PE));
            pg = pop_cnt; wg = wr_cnt;
            repeat (8) tick();
            check($sformatf("%s_gap_pops", tag), 64'(pop_cnt - pg), 64'd0);
            check($sformatf("%s_gap_writes", tag), 64'(wr_cnt - wg), 64'd0);
            bus.acc_rdy_i = 1'b1;
        end
        t = 0;
        while (done_cnt == d0 && t < 200) begin tick(); t++; end
        if (done_cnt == d0) check($sformatf("%s_done_timeout", tag), 64'(done_cnt - d0), 64'd1);
        repeat (4) tick();
        check($sformatf("%s_pops", tag), 64'(pop_cnt - p0), 64'(ROWS));
        check($sformatf("%s_writes", tag), 64'(wr_cnt - w0), 64'(ROWS));
        check($sformatf("%s_done_once", tag), 64'(done_cnt - d0), 64'd1);
        check($sformatf("%s_pending", tag), 64'(sb_q.size()), 64'd0);
        check($sformatf("%s_done_lat", tag), 64'(done_cyc - last_pop_cyc), 64'd3);
        check($sformatf("%s_wr_lat", tag), 64'(first_wr_cyc - first_pop_cyc), 64'd2);
        check($sformatf("%s_idle_busy", tag), 64'(busy_o), 64'd0);
    endtask

    initial begin
        int p0, d0, t;
        vecs[0] = '{11'h100, 5'd4,  1'b0, {32'hFFFFFFF0, 32'hFFFFF000, 32'h00000050, 32'h00000800}, 32'hFF80057F};
        vecs[1] = '{11'h120, 5'd0,  1'b1, {32'd200, 32'hFFFFFED4, 32'd7, 32'hFFFFFFFB}, 32'h7F000700};
        vecs[2] = '{11'h140, 5'd0,  1'b0, {32'd200, 32'hFFFFFED4, 32'd7, 32'hFFFFFFFB}, 32'h7F8007FB};
        vecs[3] = '{11'h7FE, 5'd31, 1'b0, {32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF, 32'h80000000}, 32'hFF0000FF};
        vecs[4] = '{11'h180, 5'd0,  1'b0, {32'hFFFFFF7F, 32'd128, 32'hFFFFFF80, 32'd127}, 32'h807F807F};
        vecs[5] = '{11'h1A0, 5'd1,  1'b1, {32'd3, 32'h00000100, 32'hFFFFFFFF, 32'h000000FF}, 32'h017F007F};

        start_i = 1'b0; base_addr_i = '0; shift_i = '0; relu_en_i = 1'b0;
        bus.acc_rdy_i = 1'b0; bus.acc_row_i = '0;
        repeat (3) tick();
        check("rst_rden", 64'(bus.acc_rden_o), 64'd0);
        check("rst_wport", {bus.mem2_ce0, bus.mem2_we0, bus.mem2_addr0}, 64'd0);
        check("rst_d0", 64'(bus.mem2_d0), 64'd0);
        check("rst_busy_done", {busy_o, done_o}, 64'd0);
        rst = 1'b0;
        bus.acc_rdy_i = 1'b1;
        tick();

        load_basic();
        do_run(11'h010, 5'd0, 1'b0, 1'b0, 1'b0, "basic");

        for (int i = 0; i < 6; i++) begin
            load(vecs[i].row, vecs[i].exp, ROWS);
            do_run(vecs[i].base, vecs[i].shift, vecs[i].relu, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        load_basic();
        do_run(11'h040, 5'd0, 1'b0, 1'b1, 1'b0, "gap");

        load_basic();
        do_run(11'h060, 5'd0, 1'b0, 1'b0, 1'b1, "restart");

        // Reset during READ of tile 0 aborts the run without a done pulse
        load_basic();
        p0 = pop_cnt; d0 = done_cnt;
        exp_addr = 11'h070;
        start_i = 1'b1; base_addr_i = 11'h070; shift_i = 5'd0; relu_en_i = 1'b0;
        tick();
        start_i = 1'b0;
        t = 0;
        while (pop_cnt - p0 < 2 && t < 50) begin tick(); t++; end
        check("abort_reached_read", 64'(pop_cnt - p0), 64'd2);
        rst = 1'b1;
        #1;
        check("abort_rden", 64'(bus.acc_rden_o), 64'd0);
        check("abort_wport", {bus.mem2_ce0, bus.mem2_we0, bus.mem2_addr0}, 64'd0);
        check("abort_busy_done", {busy_o, done_o}, 64'd0);
        repeat (3) tick();
        rst = 1'b0;
        p0 = pop_cnt;
        repeat (10) tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_no_pops", 64'(pop_cnt - p0), 64'd0);
        rows_q.delete(); exp_dq.delete(); sb_q.delete();
        load_basic();
        do_run(11'h070, 5'd0, 1'b0, 1'b0, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/acc_writeback.md
Name: acc_writeback

Overview:
- Drain engine at the output end of the GEMM datapath, the write-side counterpart of the conv data mover.
- Pops completed partial-sum rows out of the ACC column FIFOs and requantizes each PSUM_WIDTH lane to DATA_WIDTH: arithmetic shift, optional ReLU, signed saturation.
- Writes packed rows into the output GLB bank (mem2), which becomes the next layer's ifmap memory.
- Handles TILE_NUM tiles of PE_SIZE rows per run.

Parameters:
- DATA_WIDTH, 8, output element width (signed).
- PSUM_WIDTH, 32, accumulator lane width (signed).
- PE_SIZE, 14, lanes per row and rows per tile.
- TILE_NUM, 5, tiles per run.
- MEM2_ADDR_WIDTH, 11, output memory address width.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle run request.
- base_addr_i  in  MEM2_ADDR_WIDTH  first write address; sampled on accepted start.
- shift_i  in  5  arithmetic right-shift amount; sampled on accepted start.
- relu_en_i  in  1  clamp negatives to 0; sampled on accepted start.
- acc_rdy_i  in  1  ACC holds at least one complete tile (PE_SIZE rows).
- acc_rden_o  out  1  ACC FIFO pop; data is returned one cycle later.
- acc_row_i  in  PE_SIZE*PSUM_WIDTH  popped row; lane k is bits [k*PSUM_WIDTH +: PSUM_WIDTH].
- mem2_addr0  out  MEM2_ADDR_WIDTH  write address.
- mem2_ce0  out  1  chip enable.
- mem2_we0  out  1  write enable.
- mem2_d0  out  PE_SIZE*DATA_WIDTH  packed requantized row.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse after the final write.

Behaviour:
- Interface (decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: every output 0, FSM in IDLE, all counters 0.
- FSM states: IDLE, WAIT, READ, FLUSH, DONE.
  - IDLE: start_i=1 latches base_addr_i, shift_i and relu_en_i, clears tile_cnt and row_cnt, then moves to WAIT. start_i is ignored in every other state.
  - WAIT: when acc_rdy_i=1, move to READ.
  - READ: acc_rden_o=1 every cycle for exactly PE_SIZE consecutive cycles; row_cnt counts 0..PE_SIZE-1. On the last row, tile_cnt increments. If more tiles remain, go to WAIT; otherwise go to FLUSH.
  - FLUSH: hold 2 cycles so the pipeline empties, then go to DONE.
  - DONE: done_o=1 for one cycle, then return to IDLE. busy_o=0 from IDLE onward.
- acc_rdy_i is sampled only in WAIT. A tile is read without pause once READ begins; the ACC guarantees the data.
- Pipeline:
  - Cycle t: acc_rden_o=1.
  - Cycle t+1: acc_row_i valid; captured at the end of t+1.
  - Cycle t+2: the registered mem2_ce0=mem2_we0=1, mem2_addr0 and mem2_d0 are presented.
  - Pop-to-write latency is 2 cycles; throughput is 1 row per clock within a tile.
- Address: base + tile_cnt*PE_SIZE + row_cnt, equivalently a running counter incremented per write. Wrap-around modulo 2^MEM2_ADDR_WIDTH is permitted and not flagged.
- Requantization, per lane, all signed:
  - s = psum >>> shift (sign-extending).
  - If relu_en and s<0, then s = 0.
  - Saturate s to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Lane k of the row maps to lane k of mem2_d0.
- Idle write port: mem2_ce0=mem2_we0=0 and mem2_d0 holds its last value.
- rst mid-run: all activity aborts immediately, outputs clear, and no done_o is produced. The ACC contents are not this block's concern.

Decomposition:
- Shared package gemm_pkg holds:
  - widths DATA_WIDTH, PSUM_WIDTH, PE_SIZE;
  - state encoding wb_state_t (IDLE, WAIT, READ, FLUSH, DONE);
  - constants SAT_MAX and SAT_MIN.
- One sub-module: psum_requant, a combinational single-lane shift/ReLU/saturate. It is instantiated PE_SIZE times with a generate loop.

Test Plan (PE_SIZE=4, TILE_NUM=2, DATA_WIDTH=8, PSUM_WIDTH=32):
- Basic run:
  - Stimulus: start with base=0x010, shift=0, relu=0; acc_rdy_i held high; row r lanes = r+1.
  - Required: acc_rden_o high 4 cycles; first write 2 cycles after the first pop; 8 writes to 0x010..0x017 with lanes 1..4; done_o pulses once, 3 cycles after the last pop.
- Shift and saturation, with shift=4:
  - psum 0x00000800 -> 0x7F (saturated).
  - psum 0x00000050 -> 0x05.
  - psum 0xFFFFF000 -> 0x80.
  - psum 0xFFFFFFF0 -> 0xFF.
- ReLU: relu=1, lanes {-5, 7, -300, 200}, shift=0 -> mem2_d0 lanes {0x00, 0x07, 0x00, 0x7F}.
- Backpressure gap:
  - Stimulus: acc_rdy_i low for 10 cycles between tile 0 and tile 1.
  - Required: no pops or writes during the gap; tile 1 writes to base+4..base+7; total of exactly 8 writes.
- Start while busy: a second start_i pulse mid-run with base=0x100 is ignored; all addresses follow the first base.
- Reset mid-run: rst asserted during READ of tile 0 clears all outputs asynchronously; there is no done_o. A fresh start afterwards completes normally from row 0.
